lc3_int_arbiter: RTL and testbench
==================================

// Module: lc3_int_arbiter
// PURPOSE
//  Collects interrupt requests from up to N_DEV memory-mapped devices and selects one winner.
//  Presents the winner to the LC-3 datapath on IRQ/INTP/INTV, and holds it until the control
//  FSM acknowledges that it has loaded the vector.
//  Sits between the device layer and lc3 control/datapath. Filters requests against the
//  current PSR priority and rotates fairly among devices of equal priority.
// PARAMETERS
//  N_DEV   4   number of requesting devices, legal 1..8
//  IDX_W   3   winner-index width, >= $clog2(N_DEV), min 1
// PORTS
//  clk       in   1        system clock, rising edge
//  rst       in   1        asynchronous active-high reset
//  dev_req   in   N_DEV    per-device request line; a rising edge posts an interrupt
//  dev_pri   in   3*N_DEV  per-device priority, device i at [3i+2:3i]
//  dev_vec   in   8*N_DEV  per-device vector, device i at [8i+7:8i]
//  cur_pri   in   3        current PSR[10:8] from datapath
//  int_ack   in   1        control FSM has taken the interrupt (vector loaded), 1-cycle pulse
//  IRQ       out  1        1-cycle strobe to datapath; datapath latches INTP on it
//  INTP      out  3        winner priority
//  INTV      out  8        winner vector, datapath forms {8'h01,INTV}
//  dev_ack   out  N_DEV    one-hot 1-cycle pulse to the serviced device
//  busy      out  1        winner is latched and not yet acknowledged
// BEHAVIOUR
//  Reset: IRQ=0, INTP=0, INTV=0, dev_ack=0, busy=0. State=IDLE, pending=0, req_q=0, rr_ptr=0.
//  Edge detect: req_q<=dev_req each clk; rise[i]=dev_req[i]&~req_q[i]; rise sets pending[i].
//  Level-held requests post once only.
//  elig[i] = pending[i] & (pri_i != 0) & (pri_i > cur_pri). Priority 0 is never serviced.
//  Select: highest pri among elig. Ties go to the first elig index at or after rr_ptr, scanning
//  upward mod N_DEV.
//  FSM:
//   IDLE: if |elig, latch win_idx, INTP and INTV from the selection; go REQ. Otherwise stay.
//   REQ:  IRQ=1 for exactly this cycle; busy=1; go WAIT (or ACK if int_ack this cycle).
//   WAIT: busy=1; INTP/INTV held stable.
//         - If a device is elig with pri > INTP, re-latch the new winner and go REQ (preempt).
//         - On int_ack, go ACK; int_ack wins over preemption in the same cycle.
//   ACK:  dev_ack[win_idx]=1 for 1 cycle; pending[win_idx] cleared; rr_ptr <= win_idx+1 wraps
//         to 0 at N_DEV; go IDLE.
//  Latency: rise sampled at edge k -> pending after k -> winner latched at k+1 -> IRQ high in
//  the cycle after k+1.
//  Same cycle rise[i] and ACK clear of pending[i]: set wins (a new event is kept).
//  int_ack in IDLE is ignored (no dev_ack, no state change).
//  If cur_pri rises during WAIT and the winner becomes inelig: hold and wait for ack.
//  Datapath INT gating decides whether the interrupt is taken.
//  INTP/INTV keep their last winner values in IDLE. They change only on a latch.
//  rst mid-operation: everything returns to reset values; a held IRQ or pending event is lost.
// CONFIGURATION
//  IRQ_MASK_EN defined: adds ports mask_we (in,1) and mask_din (in,N_DEV), and register irq_mask.
//   - irq_mask resets to all ones and loads mask_din on mask_we.
//   - elig additionally requires irq_mask[i].
//   - Masked devices still latch pending and are serviced once unmasked.
//  IRQ_MASK_EN undefined: the ports and register are absent; all devices are enabled.
// TESTING
//  1 Reset: assert rst mid-WAIT -> IRQ=0, busy=0, dev_ack=0, INTP=0, INTV=0 immediately.
//    No IRQ after release.
//  2 Single: dev1 pri=4 vec=8'h80, cur_pri=0, rise at edge k -> IRQ at cycle k+2, INTP=4,
//    INTV=80. Ack -> dev_ack=4'b0010 next cycle.
//  3 Priority: dev0 pri=2 and dev3 pri=6 rise together -> dev3 served first. After its ack,
//    dev0 gets IRQ with INTP=2.
//  4 Round-robin: dev0..3 all pri=3, all rise, ack each -> service order 0,1,2,3. Re-post all
//    -> order 0,1,2,3 again (rr_ptr wrapped to 0).
//  5 Filter/preempt: cur_pri=5 with dev2 pri=5 -> no IRQ. dev1 pri=1 waiting in WAIT, then
//    dev0 pri=7 rises -> second IRQ with INTP=7; ack -> dev_ack=0001, dev1 still pending.
//  6 IRQ_MASK_EN: mask_din=4'b1110, dev0 rise -> no IRQ. Unmask -> IRQ for dev0 within 2 cycles.

Source files
------------

// File: rtl/lc3_int_arbiter.sv
// LC-3 interrupt arbiter: edge-posted device requests, PSR-priority filter, round-robin tie-break.
// Optional IRQ_MASK_EN adds a per-device enable mask loaded through mask_we/mask_din.
module lc3_int_arbiter #(
  parameter int N_DEV = 4,
  parameter int IDX_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DEV-1:0]   dev_req,
  input  logic [3*N_DEV-1:0] dev_pri,
  input  logic [8*N_DEV-1:0] dev_vec,
  input  logic [2:0]         cur_pri,
  input  logic               int_ack,
`ifdef IRQ_MASK_EN
  input  logic               mask_we,
  input  logic [N_DEV-1:0]   mask_din,
`endif
  output logic               IRQ,
  output logic [2:0]         INTP,
  output logic [7:0]         INTV,
  output logic [N_DEV-1:0]   dev_ack,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACK} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [N_DEV-1:0]   req_q;
  logic [N_DEV-1:0]   pending;
  logic [N_DEV-1:0]   pending_nxt;
  logic [N_DEV-1:0]   rise;
  logic [N_DEV-1:0]   elig;
  logic [N_DEV-1:0]   mask_en;
  logic [N_DEV-1:0]   win_oh;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_nxt;
  logic [IDX_W-1:0]   win_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [2:0]         sel_pri;
  logic [7:0]         sel_vec;
  logic               latch;

`ifdef IRQ_MASK_EN
  logic [N_DEV-1:0]   irq_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_mask <= '1;
    end else if (mask_we) begin
      irq_mask <= mask_din;
    end
  end

  assign mask_en = irq_mask;
`else
  assign mask_en = '1;
`endif

  assign rise   = dev_req & ~req_q;
  assign win_oh = N_DEV'(1) << win_idx;
  assign rr_nxt = (int'(win_idx) == N_DEV - 1) ? '0 : win_idx + IDX_W'(1);

  // A new rising edge overrides the clear of the device being acknowledged.
  always_comb begin
    pending_nxt = pending;
    if (state == S_ACK) begin
      pending_nxt = pending & ~win_oh;
    end else begin
      pending_nxt = pending;
    end
    pending_nxt = pending_nxt | rise;
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_DEV; i++) begin
      elig[i] = pending[i] & mask_en[i] & (dev_pri[3*i +: 3] != 3'd0) &
                (dev_pri[3*i +: 3] > cur_pri);
    end
  end

  // Scan from rr_ptr upward; strict '>' keeps the first index of an equal-priority tie.
  always_comb begin : sel_proc
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_pri   = 3'd0;
    sel_vec   = 8'd0;
    for (int off = 0; off < N_DEV; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_DEV) begin
        idx = idx - N_DEV;
      end else begin
        idx = idx;
      end
      if (elig[idx] && (dev_pri[3*idx +: 3] > sel_pri)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(idx);
        sel_pri   = dev_pri[3*idx +: 3];
        sel_vec   = dev_vec[8*idx +: 8];
      end else begin
        sel_found = sel_found;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_found) begin
          latch     = 1'b1;
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        state_nxt = int_ack ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        if (int_ack) begin
          state_nxt = S_ACK;
        end else if (sel_found && (sel_pri > INTP)) begin
          latch     = 1'b1;
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      req_q   <= '0;
      pending <= '0;
      rr_ptr  <= '0;
      win_idx <= '0;
      INTP    <= 3'd0;
      INTV    <= 8'd0;
      IRQ     <= 1'b0;
      busy    <= 1'b0;
      dev_ack <= '0;
    end else begin
      state   <= state_nxt;
      req_q   <= dev_req;
      pending <= pending_nxt;
      if (latch) begin
        win_idx <= sel_idx;
        INTP    <= sel_pri;
        INTV    <= sel_vec;
      end
      if (state == S_ACK) begin
        rr_ptr <= rr_nxt;
      end
      IRQ     <= (state_nxt == S_REQ);
      busy    <= (state_nxt == S_REQ) || (state_nxt == S_WAIT);
      dev_ack <= (state_nxt == S_ACK) ? win_oh : '0;
    end
  end

endmodule

// File: tb/tb_lc3_int_arbiter.sv
// Directed plus randomized bench for lc3_int_arbiter against a transaction-level winner model.
module tb_lc3_int_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   dev_req = '0;
  logic [3*N-1:0] dev_pri;
  logic [8*N-1:0] dev_vec;
  logic [2:0]     cur_pri = 3'd0;
  logic           int_ack = 1'b0;
  logic           IRQ;
  logic [2:0]     INTP;
  logic [7:0]     INTV;
  logic [N-1:0]   dev_ack;
  logic           busy;
`ifdef IRQ_MASK_EN
  logic           mask_we = 1'b0;
  logic [N-1:0]   mask_din = '1;
`endif

  logic [2:0] pri [N];
  logic [7:0] vec [N];
  bit         m_pend [N];
  bit         m_mask [N];
  int         m_rr;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  always_comb begin
    dev_pri = '0;
    dev_vec = '0;
    for (int i = 0; i < N; i++) begin
      dev_pri[3*i +: 3] = pri[i];
      dev_vec[8*i +: 8] = vec[i];
    end
  end

  lc3_int_arbiter #(.N_DEV(N), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .dev_req(dev_req), .dev_pri(dev_pri), .dev_vec(dev_vec),
    .cur_pri(cur_pri), .int_ack(int_ack),
`ifdef IRQ_MASK_EN
    .mask_we(mask_we), .mask_din(mask_din),
`endif
    .IRQ(IRQ), .INTP(INTP), .INTV(INTV), .dev_ack(dev_ack), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner = highest eligible priority, ties broken by smallest distance upward from rr.
  function automatic int pick();
    int best, bp, bd, p, d;
    best = -1; bp = 0; bd = N;
    for (int i = 0; i < N; i++) begin
      p = int'(pri[i]);
      d = (i - m_rr + N) % N;
      if (m_pend[i] && m_mask[i] && p != 0 && p > int'(cur_pri)) begin
        if (p > bp || (p == bp && d < bd)) begin
          best = i; bp = p; bd = d;
        end
      end
    end
    return best;
  endfunction

  task automatic post(input logic [N-1:0] bits);
    dev_req = bits;
    for (int i = 0; i < N; i++) if (bits[i]) m_pend[i] = 1'b1;
    step();
    dev_req = '0;
  endtask

  task automatic wait_irq(output bit got);
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      step();
      if (IRQ === 1'b1) got = 1'b1;
    end
    chk("irq_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic do_ack(input int w);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("dev_ack", 32'(dev_ack), 32'(1) << w);
    chk("busy_ack", 32'(busy), 32'd0);
    m_pend[w] = 1'b0;
    m_rr = (w + 1) % N;
    step();
    chk("dev_ack_pulse", 32'(dev_ack), 32'd0);
  endtask

  task automatic serve_one(input int w);
    bit got;
    int h;
    wait_irq(got);
    chk("intp", 32'(INTP), 32'(pri[w]));
    chk("intv", 32'(INTV), 32'(vec[w]));
    chk("busy_req", 32'(busy), 32'd1);
    h = $urandom_range(0, 2);
    for (int j = 0; j < h; j++) begin
      step();
      chk("irq_once", 32'(IRQ), 32'd0);
      chk("busy_wait", 32'(busy), 32'd1);
      chk("intp_hold", 32'(INTP), 32'(pri[w]));
    end
    do_ack(w);
  endtask

  task automatic quiet(input string tag);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk({tag, "_idle_ack"}, 32'(dev_ack), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk({tag, "_no_irq"}, 32'(IRQ), 32'd0);
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic serve_all();
    while (pick() >= 0) serve_one(pick());
    quiet("drained");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_rr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    for (int i = 0; i < N; i++) begin
      pri[i] = 3'd0; vec[i] = 8'd0; m_pend[i] = 1'b0; m_mask[i] = 1'b1;
    end
    m_rr = 0;
    step();
    step();
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(dev_ack), 32'd0);
    chk("rst_intp", 32'(INTP), 32'd0);
    chk("rst_intv", 32'(INTV), 32'd0);
    rst = 1'b0;

    // Reset while waiting for acknowledge.
    pri[1] = 3'd4; vec[1] = 8'h80;
    post(4'b0010);
    wait_irq(got);
    step();
    chk("t1_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_irq", 32'(IRQ), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ack", 32'(dev_ack), 32'd0);
    chk("t1_intp", 32'(INTP), 32'd0);
    chk("t1_intv", 32'(INTV), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_rr = 0;
    quiet("t1_after");

    // Single device, exact latency, level-held request posts once.
    dev_req = 4'b0010;
    m_pend[1] = 1'b1;
    step();
    chk("t2_irq_early", 32'(IRQ), 32'd0);
    step();
    chk("t2_irq", 32'(IRQ), 32'd1);
    chk("t2_intp", 32'(INTP), 32'd4);
    chk("t2_intv", 32'(INTV), 32'h80);
    do_ack(1);
    quiet("t2_level");
    dev_req = '0;
    step();

    // Priority order.
    pri[0] = 3'd2; vec[0] = 8'h10; pri[3] = 3'd6; vec[3] = 8'h33; pri[1] = 3'd0;
    post(4'b1001);
    serve_one(3);
    serve_one(0);
    quiet("t3");

    // Round robin, twice.
    do_reset();
    for (int i = 0; i < N; i++) begin pri[i] = 3'd3; vec[i] = 8'(8'h40 + i); end
    for (int r = 0; r < 2; r++) begin
      post(4'b1111);
      for (int i = 0; i < N; i++) serve_one(i);
      quiet("t4");
    end

    // Filter by cur_pri, then preemption in WAIT.
    cur_pri = 3'd5;
    for (int i = 0; i < N; i++) pri[i] = 3'd0;
    pri[2] = 3'd5;
    post(4'b0100);
    quiet("t5_filter");
    pri[2] = 3'd0; cur_pri = 3'd0;
    pri[1] = 3'd1; vec[1] = 8'h91; pri[0] = 3'd7; vec[0] = 8'h07;
    post(4'b0010);
    wait_irq(got);
    chk("t5_intp_low", 32'(INTP), 32'd1);
    step();
    chk("t5_busy", 32'(busy), 32'd1);
    post(4'b0001);
    wait_irq(got);
    chk("t5_intp_pre", 32'(INTP), 32'd7);
    chk("t5_intv_pre", 32'(INTV), 32'h07);
    do_ack(0);
    serve_one(1);
    quiet("t5_end");

`ifdef IRQ_MASK_EN
    // Masked device stays pending until unmasked.
    mask_din = 4'b1110; mask_we = 1'b1;
    step();
    mask_we = 1'b0; m_mask[0] = 1'b0;
    pri[0] = 3'd3; vec[0] = 8'hA0;
    post(4'b0001);
    quiet("t6_masked");
    mask_din = 4'b1111; mask_we = 1'b1;
    step();
    mask_we = 1'b0; m_mask[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin
      step();
      if (IRQ === 1'b1) got = 1'b1;
    end
    chk("t6_unmask_irq", {31'd0, got}, 32'd1);
    chk("t6_intv", 32'(INTV), 32'hA0);
    do_ack(0);
`endif

    // Randomized rounds against the model.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) begin
        pri[i] = 3'($urandom_range(0, 7));
        vec[i] = 8'($urandom_range(0, 255));
      end
      cur_pri = 3'($urandom_range(0, 4));
      serve_all();
      post(N'($urandom_range(1, 15)));
      serve_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
